// File: rtl/regfile_mp_sb_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default parameter values for regfile_mp_sb
//   addr_t    : address type wide enough for any supported ADDR_W (callers zero-extend)
//   wr_hit_t  : {hit, sel1} result of the write-port match
//   wr_hit()  : tells whether an address is written this cycle and by which port
//               (port 1 wins when both ports target the same address)
package regfile_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;
  localparam int ADDR_MAX_W = 32;

  typedef logic [ADDR_MAX_W-1:0] addr_t;

  typedef struct packed {
    logic hit;   // some enabled write port targets addr
    logic sel1;  // the stored value comes from port 1
  } wr_hit_t;

  function automatic wr_hit_t wr_hit(input addr_t addr,
                                     input logic  we0,
                                     input addr_t waddr0,
                                     input logic  we1,
                                     input addr_t waddr1);
    wr_hit_t r;
    r.sel1 = we1 && (waddr1 == addr);
    r.hit  = r.sel1 || (we0 && (waddr0 == addr));
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// regfile_scoreboard: one busy flag per register for RAW hazard detection.
//   clk, rst_n : clock, asynchronous active-low reset (all flags cleared)
//   sb_set     : issue of an instruction writing register sb_addr -> flag set
//   sb_addr    : destination register being issued
//   clr        : per-register writeback hit vector -> flag cleared
//   busy       : all busy flags
//   any_busy   : OR of all busy flags
// A set and a clear of the same register in one cycle leave it busy: the set
// belongs to a newer producer than the value being written back.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [DEPTH-1:0]  clr,
  output logic [DEPTH-1:0]  busy,
  output logic              any_busy
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] busy_q;

  always_comb begin
    set_vec = '0;
    if (sb_set) set_vec[sb_addr] = 1'b1;
    // Register 0 is hard-wired when ZERO_REG is set, so it never has a producer.
    if (ZERO_REG != 0) set_vec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= set_vec | (busy_q & ~clr);
    end
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with busy scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   we0/waddr0/wdata0   : write port 0 (ALU writeback)
//   we1/waddr1/wdata1   : write port 1 (load writeback), wins on address clash
//   raddr  [NUM_RD*ADDR_W] : read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata  [NUM_RD*DATA_W] : combinational read data, port i at [i*DATA_W +: DATA_W]
//   rbusy  [NUM_RD]        : busy flag of the register each port reads
//   sb_set/sb_addr      : mark destination register busy at issue
//   any_busy            : at least one register is busy
// Build option REGFILE_BYPASS_EN: when defined, a read of an address written in
// the same cycle returns the write data (port 1 first) and reports not busy,
// unless that address is also being issued. When undefined, reads come only
// from the array and there is no combinational path from the write ports.
// While rst_n is low all read outputs are forced to 0.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wr_en;
  logic [DEPTH-1:0]  wr_sel1;
  logic [DEPTH-1:0]  busy;
  addr_t             wa0;
  addr_t             wa1;

  assign wa0 = addr_t'(waddr0);
  assign wa1 = addr_t'(waddr1);

  // Write decode: one enable and one port select per register.
  always_comb begin
    wr_en   = '0;
    wr_sel1 = '0;
    for (int n = 0; n < DEPTH; n++) begin
      {wr_en[n], wr_sel1[n]} = wr_hit(addr_t'(n), we0, wa0, we1, wa1);
    end
    if (ZERO_REG != 0) begin
      wr_en[0]   = 1'b0;
      wr_sel1[0] = 1'b0;
    end
  end

  // Storage array. A write in flight when reset asserts is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (wr_en[n]) regs[n] <= wr_sel1[n] ? wdata1 : wdata0;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .clr     (wr_en),
    .busy    (busy),
    .any_busy(any_busy)
  );

  // Read ports.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;
    logic              rd_busy;
`ifdef REGFILE_BYPASS_EN
    wr_hit_t           byp;
`endif

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val  = regs[ra];
      rd_busy = busy[ra];
`ifdef REGFILE_BYPASS_EN
      byp = wr_hit(addr_t'(ra), we0, wa0, we1, wa1);
      if (byp.hit) begin
        rd_val = byp.sel1 ? wdata1 : wdata0;
        // The value being forwarded completes the old producer; only a
        // simultaneous issue to the same register keeps it marked busy.
        if (!(sb_set && (sb_addr == ra))) rd_busy = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end
      if (!rst_n) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd_val;
    assign rbusy[i]                  = rd_busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: self-checking bench for regfile_mp_sb.
//   dut_a: DATA_W=4, ADDR_W=4, NUM_RD=2, ZERO_REG=0 (directed table and corner sequences)
//   dut_b: DATA_W=8, ADDR_W=4, NUM_RD=3, ZERO_REG=1 (register-0 behaviour and random traffic)
// Honours REGFILE_BYPASS_EN in the read-during-write expectations and the model.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- dut_a ----------------
  logic       a_we0, a_we1, a_sb_set, a_any;
  logic [3:0] a_waddr0, a_waddr1, a_wdata0, a_wdata1, a_sb_addr;
  logic [7:0] a_raddr, a_rdata;
  logic [1:0] a_rbusy;

  regfile_mp_sb #(.DATA_W(4), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(a_we0), .waddr0(a_waddr0), .wdata0(a_wdata0),
    .we1(a_we1), .waddr1(a_waddr1), .wdata1(a_wdata1),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr), .any_busy(a_any)
  );

  // ---------------- dut_b ----------------
  logic        b_we0, b_we1, b_sb_set, b_any;
  logic [3:0]  b_waddr0, b_waddr1, b_sb_addr;
  logic [7:0]  b_wdata0, b_wdata1;
  logic [11:0] b_raddr;
  logic [23:0] b_rdata;
  logic [2:0]  b_rbusy;

  regfile_mp_sb #(.DATA_W(8), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(b_we0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .any_busy(b_any)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we0; logic [3:0] wa0; logic [3:0] wd0;
    logic       we1; logic [3:0] wa1; logic [3:0] wd1;
    logic       sb;  logic [3:0] sa;
    logic [3:0] ra0; logic [3:0] ra1;
    logic [3:0] e0;  logic [3:0] e1;
    logic [1:0] eb;  logic       ea;
  } vec_t;

  localparam int NVEC = 11;
  vec_t tbl [NVEC];

  // ---------------- driver tasks ----------------
  task automatic a_idle();
    a_we0 = 1'b0; a_waddr0 = 4'h0; a_wdata0 = 4'h0;
    a_we1 = 1'b0; a_waddr1 = 4'h0; a_wdata1 = 4'h0;
    a_sb_set = 1'b0; a_sb_addr = 4'h0;
  endtask

  task automatic b_idle();
    b_we0 = 1'b0; b_waddr0 = 4'h0; b_wdata0 = 8'h00;
    b_we1 = 1'b0; b_waddr1 = 4'h0; b_wdata1 = 8'h00;
    b_sb_set = 1'b0; b_sb_addr = 4'h0;
  endtask

  // One row: drive writes/issue for one edge, then read back with the write
  // ports idle so the result does not depend on forwarding.
  task automatic apply_row(input vec_t v, input int idx);
    @(negedge clk);
    a_we0 = v.we0; a_waddr0 = v.wa0; a_wdata0 = v.wd0;
    a_we1 = v.we1; a_waddr1 = v.wa1; a_wdata1 = v.wd1;
    a_sb_set = v.sb; a_sb_addr = v.sa;
    @(posedge clk);
    #1;
    a_idle();
    a_raddr = {v.ra1, v.ra0};
    #1;
    check($sformatf("row%0d_rdata0", idx), a_rdata[3:0], v.e0);
    check($sformatf("row%0d_rdata1", idx), a_rdata[7:4], v.e1);
    check($sformatf("row%0d_rbusy", idx), a_rbusy, v.eb);
    check($sformatf("row%0d_any_busy", idx), a_any, v.ea);
  endtask

  // ---------------- reference model for dut_b ----------------
  logic [7:0]  mdl_reg [16];
  logic [15:0] mdl_busy;

  initial begin
    a_idle(); b_idle();
    a_raddr = 8'h30;
    b_raddr = 12'h000;

    //            we0  wa0   wd0   we1  wa1   wd1   sb   sa    ra0   ra1   e0    e1    eb     ea
    tbl[0]  = '{1'b1,4'h2,4'h5, 1'b1,4'h7,4'h9, 1'b0,4'h0, 4'h2,4'h7, 4'h5,4'h9, 2'b00,1'b0};
    tbl[1]  = '{1'b1,4'h4,4'h1, 1'b1,4'h4,4'h6, 1'b0,4'h0, 4'h4,4'h2, 4'h6,4'h5, 2'b00,1'b0};
    tbl[2]  = '{1'b0,4'h0,4'h0, 1'b0,4'h0,4'h0, 1'b1,4'h5, 4'h5,4'h4, 4'h0,4'h6, 2'b01,1'b1};
    tbl[3]  = '{1'b1,4'h5,4'h3, 1'b0,4'h0,4'h0, 1'b1,4'h5, 4'h5,4'h7, 4'h3,4'h9, 2'b01,1'b1};
    tbl[4]  = '{1'b0,4'h0,4'h0, 1'b1,4'h5,4'h2, 1'b0,4'h0, 4'h5,4'h5, 4'h2,4'h2, 2'b00,1'b0};
    tbl[5]  = '{1'b1,4'h3,4'hA, 1'b0,4'h0,4'h0, 1'b1,4'h1, 4'h3,4'h1, 4'hA,4'h0, 2'b10,1'b1};
    tbl[6]  = '{1'b0,4'h0,4'h0, 1'b1,4'h1,4'h7, 1'b1,4'h8, 4'h1,4'h8, 4'h7,4'h0, 2'b10,1'b1};
    tbl[7]  = '{1'b1,4'h8,4'hF, 1'b0,4'h0,4'h0, 1'b0,4'h0, 4'h8,4'h0, 4'hF,4'h0, 2'b00,1'b0};
    tbl[8]  = '{1'b1,4'h9,4'h4, 1'b1,4'hA,4'hB, 1'b1,4'h9, 4'h9,4'hA, 4'h4,4'hB, 2'b01,1'b1};
    tbl[9]  = '{1'b0,4'h0,4'h0, 1'b0,4'h0,4'h0, 1'b1,4'h9, 4'h9,4'h0, 4'h4,4'h0, 2'b01,1'b1};
    tbl[10] = '{1'b0,4'h0,4'h0, 1'b1,4'h9,4'hE, 1'b0,4'h0, 4'h9,4'hF, 4'hE,4'h0, 2'b00,1'b0};

    // ---- reset state ----
    #2;
    check("in_reset_rdata", a_rdata, 8'h00);
    check("in_reset_any_busy", a_any, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_rdata", a_rdata, 8'h00);
    check("post_reset_rbusy", a_rbusy, 2'b00);

    // ---- table: dual writes, same-address priority, scoreboard set/clear ----
    for (int i = 0; i < NVEC; i++) apply_row(tbl[i], i);

    // ---- read-during-write on r6 (old 1, new C) ----
    @(negedge clk);
    a_we0 = 1'b1; a_waddr0 = 4'h6; a_wdata0 = 4'h1;
    a_sb_set = 1'b1; a_sb_addr = 4'h6;
    @(negedge clk);
    a_idle();
    a_raddr = 8'h06;
    #1;
    check("rdw_old_value", a_rdata[3:0], 4'h1);
    check("rdw_old_busy", a_rbusy[0], 1'b1);
    a_we0 = 1'b1; a_waddr0 = 4'h6; a_wdata0 = 4'hC;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle_rdata", a_rdata[3:0], 4'hC);
    check("rdw_same_cycle_rbusy", a_rbusy[0], 1'b0);
`else
    check("rdw_same_cycle_rdata", a_rdata[3:0], 4'h1);
    check("rdw_same_cycle_rbusy", a_rbusy[0], 1'b1);
`endif
    @(posedge clk);
    #1;
    a_idle();
    #1;
    check("rdw_next_cycle_rdata", a_rdata[3:0], 4'hC);
    check("rdw_next_cycle_rbusy", a_rbusy[0], 1'b0);
    check("rdw_next_cycle_any", a_any, 1'b0);

    // ---- asynchronous reset mid-cycle, dropping a write in flight ----
    @(negedge clk);
    a_sb_set = 1'b1; a_sb_addr = 4'h3;
    @(negedge clk);
    a_idle();
    a_raddr = 8'h33;
    #1;
    check("pre_reset_r3", a_rdata[3:0], 4'hA);
    check("pre_reset_any", a_any, 1'b1);
    a_we0 = 1'b1; a_waddr0 = 4'h3; a_wdata0 = 4'h5;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rdata", a_rdata, 8'h00);
    check("async_reset_rbusy", a_rbusy, 2'b00);
    check("async_reset_any", a_any, 1'b0);
    @(negedge clk);
    a_idle();
    rst_n = 1'b1;
    #1;
    check("after_reset_r3", a_rdata[3:0], 4'h0);
    check("after_reset_any", a_any, 1'b0);

    // ---- ZERO_REG: writes and issue to r0 are discarded ----
    @(negedge clk);
    b_we0 = 1'b1; b_waddr0 = 4'h0; b_wdata0 = 8'hFF;
    b_we1 = 1'b1; b_waddr1 = 4'h1; b_wdata1 = 8'h5A;
    b_sb_set = 1'b1; b_sb_addr = 4'h0;
    @(posedge clk);
    #1;
    b_idle();
    b_raddr = {4'h0, 4'h1, 4'h0};
    #1;
    check("zero_reg_rdata", b_rdata, {8'h00, 8'h5A, 8'h00});
    check("zero_reg_rbusy", b_rbusy, 3'b000);
    check("zero_reg_any", b_any, 1'b0);

    // ---- random traffic on dut_b against the model ----
    for (int n = 0; n < 16; n++) mdl_reg[n] = 8'h00;
    mdl_reg[1] = 8'h5A;
    mdl_busy = 16'h0000;

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      b_we0     = ($urandom_range(0, 99) < 40);
      b_waddr0  = 4'($urandom_range(0, 15));
      b_wdata0  = 8'($urandom_range(0, 255));
      b_we1     = ($urandom_range(0, 99) < 40);
      b_waddr1  = ($urandom_range(0, 3) == 0) ? b_waddr0 : 4'($urandom_range(0, 15));
      b_wdata1  = 8'($urandom_range(0, 255));
      b_sb_set  = ($urandom_range(0, 99) < 35);
      b_sb_addr = ($urandom_range(0, 3) == 0) ? b_waddr1 : 4'($urandom_range(0, 15));
      b_raddr   = 12'($urandom_range(0, 4095));
      #2;
      for (int i = 0; i < 3; i++) begin
        logic [3:0] ra;
        logic [7:0] ed;
        logic       eb;
        ra = b_raddr[i*4 +: 4];
        ed = mdl_reg[ra];
        eb = mdl_busy[ra];
`ifdef REGFILE_BYPASS_EN
        if ((b_we1 && b_waddr1 == ra) || (b_we0 && b_waddr0 == ra)) begin
          ed = (b_we1 && b_waddr1 == ra) ? b_wdata1 : b_wdata0;
          if (!(b_sb_set && b_sb_addr == ra)) eb = 1'b0;
        end
`endif
        if (ra == 4'h0) begin
          ed = 8'h00;
          eb = 1'b0;
        end
        exp_q.push_back(32'(ed));
        exp_q.push_back(32'(eb));
      end
      exp_q.push_back(32'(|mdl_busy));

      for (int i = 0; i < 3; i++) begin
        check($sformatf("rnd_c%0d_rdata%0d", c, i), 32'(b_rdata[i*8 +: 8]), exp_q.pop_front());
        check($sformatf("rnd_c%0d_rbusy%0d", c, i), 32'(b_rbusy[i]), exp_q.pop_front());
      end
      check($sformatf("rnd_c%0d_any_busy", c), 32'(b_any), exp_q.pop_front());

      @(posedge clk);
      // Register contents: port 0 then port 1, so port 1 prevails on a clash.
      if (b_we0 && b_waddr0 != 4'h0) mdl_reg[b_waddr0] = b_wdata0;
      if (b_we1 && b_waddr1 != 4'h0) mdl_reg[b_waddr1] = b_wdata1;
      // Busy: writeback clears, a new issue sets and takes precedence.
      if (b_we0) mdl_busy[b_waddr0] = 1'b0;
      if (b_we1) mdl_busy[b_waddr1] = 1'b0;
      if (b_sb_set && b_sb_addr != 4'h0) mdl_busy[b_sb_addr] = 1'b1;
    end

    @(negedge clk);
    b_idle();

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
